// File: rtl/airi5c_rf_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: widths,
// sequencer state encoding and requester identifiers.
package airi5c_rf_wr_arbiter_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned XPR_LEN        = 32;

  localparam int unsigned ADDR_W = REG_ADDR_WIDTH;
  localparam int unsigned DATA_W = XPR_LEN;

  typedef enum logic {
    ARB_IDLE,
    ARB_PAIR_HI
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_DM,
    REQ_LL,
    REQ_PL
  } req_id_t;

endpackage

// File: rtl/airi5c_rf_wr_arbiter_if.sv
// Request handshakes of the three write sources plus the register-file write
// port. The arbiter uses the slave view, requesters/register file the master view.
interface airi5c_rf_wr_arbiter_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              dm_valid_i;
  logic              dm_ready_o;
  logic [ADDR_W-1:0] dm_wa_i;
  logic [DATA_W-1:0] dm_wd_i;
  logic              dm_fpu_i;

  logic              ll_valid_i;
  logic              ll_ready_o;
  logic [ADDR_W-1:0] ll_wa_i;
  logic [DATA_W-1:0] ll_wd_i;
  logic [DATA_W-1:0] ll_wd2_i;
  logic              ll_pair_i;
  logic              ll_fpu_i;

  logic              pl_valid_i;
  logic              pl_ready_o;
  logic [ADDR_W-1:0] pl_wa_i;
  logic [DATA_W-1:0] pl_wd_i;
  logic [DATA_W-1:0] pl_wd2_i;
  logic              pl_pair_i;
  logic              pl_fpu_i;

  logic              wen_o;
  logic [ADDR_W-1:0] wa_o;
  logic [DATA_W-1:0] wd_o;
  logic              sel_fpu_o;
  logic              busy_o;
  logic              err_o;

  modport slave (
    input  dm_valid_i, dm_wa_i, dm_wd_i, dm_fpu_i,
    input  ll_valid_i, ll_wa_i, ll_wd_i, ll_wd2_i, ll_pair_i, ll_fpu_i,
    input  pl_valid_i, pl_wa_i, pl_wd_i, pl_wd2_i, pl_pair_i, pl_fpu_i,
    output dm_ready_o, ll_ready_o, pl_ready_o,
    output wen_o, wa_o, wd_o, sel_fpu_o, busy_o, err_o
  );

  modport master (
    output dm_valid_i, dm_wa_i, dm_wd_i, dm_fpu_i,
    output ll_valid_i, ll_wa_i, ll_wd_i, ll_wd2_i, ll_pair_i, ll_fpu_i,
    output pl_valid_i, pl_wa_i, pl_wd_i, pl_wd2_i, pl_pair_i, pl_fpu_i,
    input  dm_ready_o, ll_ready_o, pl_ready_o,
    input  wen_o, wa_o, wd_o, sel_fpu_o, busy_o, err_o
  );
endinterface

// File: rtl/airi5c_rr_arb2.sv
// Two-way selector with pointer register: round-robin when RR_EN=1,
// fixed a-over-b priority otherwise. Pointer 0 favours a, 1 favours b.
module airi5c_rr_arb2 #(
  parameter bit RR_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic adv,
  output logic gnt_a,
  output logic gnt_b
);
  logic ptr;
  logic prefer_b;

  assign prefer_b = RR_EN & ptr;
  assign gnt_a    = req_a & (~req_b | ~prefer_b);
  assign gnt_b    = req_b & (~req_a |  prefer_b);

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (adv && gnt_a) begin
      ptr <= 1'b1;
    end else if (adv && gnt_b) begin
      ptr <= 1'b0;
    end
  end
endmodule

// File: rtl/airi5c_rf_wr_arbiter.sv
// Register-file write-port arbiter and 64-bit pair sequencer (dm > ll/pl).
// Define AIRI5C_RF_ARB_RR_EN for round-robin between ll and pl.
module airi5c_rf_wr_arbiter
  import airi5c_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_ADDR_WIDTH,
  parameter int unsigned DATA_W = XPR_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  airi5c_rf_wr_arbiter_if.slave  bus
);
`ifdef AIRI5C_RF_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t        state, state_next;
  req_id_t           gnt;
  logic              ll_gnt, pl_gnt, arb_adv;

  logic [ADDR_W-1:0] sel_wa;
  logic [DATA_W-1:0] sel_wd, sel_wd2;
  logic              sel_pair, sel_fpu;
  logic              transfer, pair_ok, is_x0;

  logic              wen, sel_fpu_q, busy, err;
  logic [ADDR_W-1:0] wa, hi_wa;
  logic [DATA_W-1:0] wd, hi_wd;

  assign arb_adv = (state == ARB_IDLE) && !bus.dm_valid_i;

  airi5c_rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_ll_pl_arb (
    .clk   (clk_i),
    .rst   (rst_i),
    .req_a (bus.ll_valid_i),
    .req_b (bus.pl_valid_i),
    .adv   (arb_adv),
    .gnt_a (ll_gnt),
    .gnt_b (pl_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:    if (transfer && sel_pair && pair_ok) state_next = ARB_PAIR_HI;
      ARB_PAIR_HI: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt = REQ_NONE;
    if (state == ARB_IDLE) begin
      if (bus.dm_valid_i) begin
        gnt = REQ_DM;
      end else if (ll_gnt) begin
        gnt = REQ_LL;
      end else if (pl_gnt) begin
        gnt = REQ_PL;
      end
    end
  end

  assign bus.dm_ready_o = (gnt == REQ_DM);
  assign bus.ll_ready_o = (gnt == REQ_LL);
  assign bus.pl_ready_o = (gnt == REQ_PL);
  assign transfer       = (gnt != REQ_NONE);

  always_comb begin
    sel_wa   = '0;
    sel_wd   = '0;
    sel_wd2  = '0;
    sel_pair = 1'b0;
    sel_fpu  = 1'b0;
    unique case (gnt)
      REQ_DM: begin
        sel_wa  = bus.dm_wa_i;
        sel_wd  = bus.dm_wd_i;
        sel_fpu = bus.dm_fpu_i;
      end
      REQ_LL: begin
        sel_wa   = bus.ll_wa_i;
        sel_wd   = bus.ll_wd_i;
        sel_wd2  = bus.ll_wd2_i;
        sel_pair = bus.ll_pair_i;
        sel_fpu  = bus.ll_fpu_i;
      end
      REQ_PL: begin
        sel_wa   = bus.pl_wa_i;
        sel_wd   = bus.pl_wd_i;
        sel_wd2  = bus.pl_wd2_i;
        sel_pair = bus.pl_pair_i;
        sel_fpu  = bus.pl_fpu_i;
      end
      default: ;
    endcase
  end

  assign pair_ok = !sel_fpu && !sel_wa[0];
  assign is_x0   = !sel_fpu && (sel_wa == '0);

  // wa/wd/sel_fpu only move on an actual write so suppressed writes leave them unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wen       <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      sel_fpu_q <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      hi_wa     <= '0;
      hi_wd     <= '0;
    end else begin
      wen  <= 1'b0;
      busy <= 1'b0;
      err  <= 1'b0;
      if (state == ARB_PAIR_HI) begin
        wen       <= 1'b1;
        wa        <= hi_wa;
        wd        <= hi_wd;
        sel_fpu_q <= 1'b0;
      end else if (transfer) begin
        if (sel_pair && !pair_ok) begin
          err <= 1'b1;
        end else begin
          if (sel_pair) begin
            busy  <= 1'b1;
            hi_wa <= {sel_wa[ADDR_W-1:1], 1'b1};
            hi_wd <= sel_wd2;
          end
          if (!is_x0) begin
            wen       <= 1'b1;
            wa        <= sel_wa;
            wd        <= sel_wd;
            sel_fpu_q <= sel_fpu;
          end
        end
      end
    end
  end

  assign bus.wen_o     = wen;
  assign bus.wa_o      = wa;
  assign bus.wd_o      = wd;
  assign bus.sel_fpu_o = sel_fpu_q;
  assign bus.busy_o    = busy;
  assign bus.err_o     = err;
endmodule

// File: tb/tb_airi5c_rf_wr_arbiter.sv
// Directed self-checking bench for airi5c_rf_wr_arbiter; the ll/pl sharing
// expectation follows AIRI5C_RF_ARB_RR_EN.
module tb_airi5c_rf_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  airi5c_rf_wr_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  airi5c_rf_wr_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.dm_valid_i = 1'b0; bus.dm_wa_i = '0; bus.dm_wd_i = '0; bus.dm_fpu_i = 1'b0;
    bus.ll_valid_i = 1'b0; bus.ll_wa_i = '0; bus.ll_wd_i = '0; bus.ll_wd2_i = '0;
    bus.ll_pair_i  = 1'b0; bus.ll_fpu_i = 1'b0;
    bus.pl_valid_i = 1'b0; bus.pl_wa_i = '0; bus.pl_wd_i = '0; bus.pl_wd2_i = '0;
    bus.pl_pair_i  = 1'b0; bus.pl_fpu_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    n_checks++; if (bus.wen_o !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.wen_o); end
    n_checks++; if (bus.wa_o !== 5'd0) begin n_fail++; $display("FAIL reset_wa: got %0d want 0", bus.wa_o); end
    n_checks++; if (bus.wd_o !== 32'h0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", bus.wd_o); end
    n_checks++; if (bus.sel_fpu_o !== 1'b0) begin n_fail++; $display("FAIL reset_sel_fpu: got %b want 0", bus.sel_fpu_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    rst = 1'b0;
    tick();
    n_checks++; if ({bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready_idle: got %b want 000", {bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o}); end
  endtask

  task automatic test_single();
    bus.pl_valid_i = 1'b1; bus.pl_wa_i = 5'd5; bus.pl_wd_i = 32'h12345678;
    #1;
    n_checks++; if ({bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o} !== 3'b001) begin
      n_fail++; $display("FAIL single_ready: got %b want 001", {bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o}); end
    tick();
    clear_inputs();
    n_checks++; if (bus.wen_o !== 1'b1) begin n_fail++; $display("FAIL single_wen: got %b want 1", bus.wen_o); end
    n_checks++; if (bus.wa_o !== 5'd5) begin n_fail++; $display("FAIL single_wa: got %0d want 5", bus.wa_o); end
    n_checks++; if (bus.wd_o !== 32'h12345678) begin n_fail++; $display("FAIL single_wd: got %h want 12345678", bus.wd_o); end
    n_checks++; if (bus.sel_fpu_o !== 1'b0) begin n_fail++; $display("FAIL single_sel_fpu: got %b want 0", bus.sel_fpu_o); end
    tick();
    n_checks++; if (bus.wen_o !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop: got %b want 0", bus.wen_o); end
    n_checks++; if (bus.wa_o !== 5'd5) begin n_fail++; $display("FAIL single_wa_hold: got %0d want 5", bus.wa_o); end
  endtask

  task automatic test_priority();
    bus.dm_valid_i = 1'b1; bus.dm_wa_i = 5'd1; bus.dm_wd_i = 32'hD0;
    bus.ll_valid_i = 1'b1; bus.ll_wa_i = 5'd2; bus.ll_wd_i = 32'h11;
    bus.pl_valid_i = 1'b1; bus.pl_wa_i = 5'd3; bus.pl_wd_i = 32'h22;
    #1;
    n_checks++; if ({bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o} !== 3'b100) begin
      n_fail++; $display("FAIL prio_ready_dm: got %b want 100", {bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o}); end
    tick();
    bus.dm_valid_i = 1'b0;
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd1, 32'hD0}) begin
      n_fail++; $display("FAIL prio_write_dm: got wen=%b wa=%0d wd=%h want wen=1 wa=1 wd=d0", bus.wen_o, bus.wa_o, bus.wd_o); end
    #1;
    n_checks++; if ({bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o} !== 3'b010) begin
      n_fail++; $display("FAIL prio_ready_ll: got %b want 010", {bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o}); end
    tick();
    bus.ll_valid_i = 1'b0;
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd2, 32'h11}) begin
      n_fail++; $display("FAIL prio_write_ll: got wen=%b wa=%0d wd=%h want wen=1 wa=2 wd=11", bus.wen_o, bus.wa_o, bus.wd_o); end
    #1;
    n_checks++; if ({bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o} !== 3'b001) begin
      n_fail++; $display("FAIL prio_ready_pl: got %b want 001", {bus.dm_ready_o, bus.ll_ready_o, bus.pl_ready_o}); end
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd3, 32'h22}) begin
      n_fail++; $display("FAIL prio_write_pl: got wen=%b wa=%0d wd=%h want wen=1 wa=3 wd=22", bus.wen_o, bus.wa_o, bus.wd_o); end
    tick();
  endtask

  task automatic test_pair();
    bus.pl_valid_i = 1'b1; bus.pl_pair_i = 1'b1; bus.pl_wa_i = 5'd10;
    bus.pl_wd_i = 32'hA; bus.pl_wd2_i = 32'hB;
    #1;
    n_checks++; if (bus.pl_ready_o !== 1'b1) begin n_fail++; $display("FAIL pair_ready: got %b want 1", bus.pl_ready_o); end
    tick();
    clear_inputs();
    bus.dm_valid_i = 1'b1; bus.dm_wa_i = 5'd4; bus.dm_wd_i = 32'hDD;
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd10, 32'hA}) begin
      n_fail++; $display("FAIL pair_low: got wen=%b wa=%0d wd=%h want wen=1 wa=10 wd=a", bus.wen_o, bus.wa_o, bus.wd_o); end
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL pair_busy: got %b want 1", bus.busy_o); end
    #1;
    n_checks++; if (bus.dm_ready_o !== 1'b0) begin n_fail++; $display("FAIL pair_dm_blocked: got %b want 0", bus.dm_ready_o); end
    tick();
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd11, 32'hB}) begin
      n_fail++; $display("FAIL pair_high: got wen=%b wa=%0d wd=%h want wen=1 wa=11 wd=b", bus.wen_o, bus.wa_o, bus.wd_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL pair_busy_end: got %b want 0", bus.busy_o); end
    #1;
    n_checks++; if (bus.dm_ready_o !== 1'b1) begin n_fail++; $display("FAIL pair_dm_after: got %b want 1", bus.dm_ready_o); end
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd4, 32'hDD}) begin
      n_fail++; $display("FAIL pair_dm_write: got wen=%b wa=%0d wd=%h want wen=1 wa=4 wd=dd", bus.wen_o, bus.wa_o, bus.wd_o); end
    tick();
  endtask

  task automatic test_illegal_and_x0();
    bus.pl_valid_i = 1'b1; bus.pl_pair_i = 1'b1; bus.pl_wa_i = 5'd7; bus.pl_wd_i = 32'h70;
    #1;
    n_checks++; if (bus.pl_ready_o !== 1'b1) begin n_fail++; $display("FAIL odd_pair_ready: got %b want 1", bus.pl_ready_o); end
    tick();
    clear_inputs();
    bus.ll_valid_i = 1'b1; bus.ll_pair_i = 1'b1; bus.ll_fpu_i = 1'b1; bus.ll_wa_i = 5'd2;
    n_checks++; if ({bus.wen_o, bus.err_o, bus.busy_o} !== 3'b010) begin
      n_fail++; $display("FAIL odd_pair_err: got wen/err/busy=%b want 010", {bus.wen_o, bus.err_o, bus.busy_o}); end
    #1;
    n_checks++; if (bus.ll_ready_o !== 1'b1) begin n_fail++; $display("FAIL fpu_pair_ready: got %b want 1", bus.ll_ready_o); end
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.err_o} !== 2'b01) begin
      n_fail++; $display("FAIL fpu_pair_err: got wen/err=%b want 01", {bus.wen_o, bus.err_o}); end
    tick();
    n_checks++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", bus.err_o); end
    bus.pl_valid_i = 1'b1; bus.pl_wa_i = 5'd0; bus.pl_wd_i = 32'h55;
    #1;
    n_checks++; if (bus.pl_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", bus.pl_ready_o); end
    tick();
    bus.pl_fpu_i = 1'b1; bus.pl_wd_i = 32'h66;
    n_checks++; if ({bus.wen_o, bus.err_o} !== 2'b00) begin
      n_fail++; $display("FAIL x0_suppressed: got wen/err=%b want 00", {bus.wen_o, bus.err_o}); end
    tick();
    bus.pl_fpu_i = 1'b0; bus.pl_pair_i = 1'b1; bus.pl_wd_i = 32'h1; bus.pl_wd2_i = 32'h2;
    n_checks++; if ({bus.wen_o, bus.sel_fpu_o, bus.wa_o, bus.wd_o} !== {1'b1, 1'b1, 5'd0, 32'h66}) begin
      n_fail++; $display("FAIL f0_write: got wen=%b fpu=%b wa=%0d wd=%h want 1 1 0 66", bus.wen_o, bus.sel_fpu_o, bus.wa_o, bus.wd_o); end
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.busy_o} !== 2'b01) begin
      n_fail++; $display("FAIL pair_x0_low: got wen/busy=%b want 01", {bus.wen_o, bus.busy_o}); end
    tick();
    n_checks++; if ({bus.wen_o, bus.sel_fpu_o, bus.wa_o, bus.wd_o} !== {1'b1, 1'b0, 5'd1, 32'h2}) begin
      n_fail++; $display("FAIL pair_x0_high: got wen=%b fpu=%b wa=%0d wd=%h want 1 0 1 2", bus.wen_o, bus.sel_fpu_o, bus.wa_o, bus.wd_o); end
    tick();
  endtask

  task automatic test_reset_mid_pair();
    bus.ll_valid_i = 1'b1; bus.ll_pair_i = 1'b1; bus.ll_wa_i = 5'd20;
    bus.ll_wd_i = 32'h100; bus.ll_wd2_i = 32'h200;
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.busy_o} !== {1'b1, 5'd20, 1'b1}) begin
      n_fail++; $display("FAIL rstpair_low: got wen=%b wa=%0d busy=%b want 1 20 1", bus.wen_o, bus.wa_o, bus.busy_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o, bus.sel_fpu_o, bus.busy_o, bus.err_o} !== '0) begin
      n_fail++; $display("FAIL rstpair_zero: got wen=%b wa=%0d wd=%h fpu=%b busy=%b err=%b want all 0",
                         bus.wen_o, bus.wa_o, bus.wd_o, bus.sel_fpu_o, bus.busy_o, bus.err_o); end
    tick();
    n_checks++; if (bus.wen_o !== 1'b0) begin n_fail++; $display("FAIL rstpair_no_high: got %b want 0", bus.wen_o); end
    bus.pl_valid_i = 1'b1; bus.pl_wa_i = 5'd6; bus.pl_wd_i = 32'h77;
    #1;
    n_checks++; if (bus.pl_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstpair_next_ready: got %b want 1", bus.pl_ready_o); end
    tick();
    clear_inputs();
    n_checks++; if ({bus.wen_o, bus.wa_o, bus.wd_o} !== {1'b1, 5'd6, 32'h77}) begin
      n_fail++; $display("FAIL rstpair_next_write: got wen=%b wa=%0d wd=%h want 1 6 77", bus.wen_o, bus.wa_o, bus.wd_o); end
    tick();
  endtask

  task automatic test_ll_pl_sharing();
    logic       exp_ll;
    logic [4:0] exp_wa;
    bus.ll_valid_i = 1'b1; bus.ll_wa_i = 5'd8; bus.ll_wd_i = 32'h88;
    bus.pl_valid_i = 1'b1; bus.pl_wa_i = 5'd9; bus.pl_wd_i = 32'h99;
    for (int i = 0; i < 8; i++) begin
`ifdef AIRI5C_RF_ARB_RR_EN
      exp_ll = ((i % 2) == 0);
`else
      exp_ll = 1'b1;
`endif
      exp_wa = exp_ll ? 5'd8 : 5'd9;
      #1;
      n_checks++; if ({bus.ll_ready_o, bus.pl_ready_o} !== {exp_ll, ~exp_ll}) begin
        n_fail++; $display("FAIL share_grant[%0d]: got ll/pl=%b want %b", i, {bus.ll_ready_o, bus.pl_ready_o}, {exp_ll, ~exp_ll}); end
      tick();
      n_checks++; if ({bus.wen_o, bus.wa_o} !== {1'b1, exp_wa}) begin
        n_fail++; $display("FAIL share_write[%0d]: got wen=%b wa=%0d want 1 %0d", i, bus.wen_o, bus.wa_o, exp_wa); end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_priority();
    test_pair();
    test_illegal_and_x0();
    test_reset_mid_pair();
    test_ll_pl_sharing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
